efuse_shadow: RTL and testbench

//  Downstream consumer of the efuse controller's autoload byte stream. Captures the NB autoloaded

---
 rtl/efuse_shadow_if.sv | 14 +
 rtl/efuse_shadow.sv | 140 ++++++++++++++
 tb/tb_efuse_shadow.sv | 228 ++++++++++++++++++++++
 3 files changed

// File: rtl/efuse_shadow_if.sv
// Autoload byte stream from the efuse controller into the shadow block.
interface efuse_shadow_if;
  logic       efuse_autoload_vld;
  logic [7:0] efuse_autoload_addr;
  logic [7:0] efuse_autoload_data;
  logic       efuse_autoload_done;

  modport master (
    output efuse_autoload_vld, efuse_autoload_addr, efuse_autoload_data, efuse_autoload_done
  );
  modport slave (
    input  efuse_autoload_vld, efuse_autoload_addr, efuse_autoload_data, efuse_autoload_done
  );
endinterface

// File: rtl/efuse_shadow.sv
// efuse_shadow: captures the efuse autoload image into a shadow array, verifies
// an additive checksum (last byte) and blank state, then publishes the trim
// vector. Bad or blank images publish DEFAULT_TRIM instead.
// Optional: define EFUSE_SHADOW_OVR_EN to add a register override of trim_data/trim_vld.
module efuse_shadow #(
  parameter int              NB           = 32,
  parameter logic [NB*8-1:0] DEFAULT_TRIM = '0
) (
  input  logic                  clk,
  input  logic                  rst_n,
  efuse_shadow_if.slave         al,
  input  logic [$clog2(NB)-1:0] rg_shadow_raddr,
  output logic [7:0]            rg_shadow_rdata,
  output logic [NB*8-1:0]       trim_data,
  output logic                  trim_vld,
  output logic                  rg_shadow_sum_err,
  output logic                  rg_shadow_blank,
`ifdef EFUSE_SHADOW_OVR_EN
  input  logic                  rg_trim_ovr_en,
  input  logic [NB*8-1:0]       rg_trim_ovr_data,
`endif
  output logic                  shadow_busy
);
  localparam int AW = $clog2(NB);

  typedef enum logic [2:0] {S_IDLE, S_LOAD, S_CHECK, S_PASS, S_FAIL} state_e;

  state_e                state_q, state_d;
  logic [NB-1:0][7:0]    shadow_q, shadow_d;
  logic [AW-1:0]         idx_q, idx_d;
  logic [7:0]            acc_q, acc_d;
  logic [NB*8-1:0]       trim_q, trim_d;
  logic                  tvld_q, tvld_d;
  logic                  err_q, err_d;
  logic                  blank_q, blank_d;
  logic                  busy_q, busy_d;
  logic                  wr_en;
  logic                  cmp_blank, cmp_err;

  // Bytes land in any state except CHECK; out-of-range indices are dropped.
  assign wr_en     = al.efuse_autoload_vld && (state_q != S_CHECK) &&
                     ({24'd0, al.efuse_autoload_addr} < 32'(NB));
  assign cmp_blank = ~|shadow_q;
  assign cmp_err   = (acc_q != shadow_q[NB-1]);

  // Next-state, shadow writes, checksum walk and compare.
  always_comb begin
    state_d  = state_q;
    shadow_d = shadow_q;
    idx_d    = idx_q;
    acc_d    = acc_q;
    trim_d   = trim_q;
    tvld_d   = tvld_q;
    err_d    = err_q;
    blank_d  = blank_q;
    if (wr_en) shadow_d[al.efuse_autoload_addr[AW-1:0]] = al.efuse_autoload_data;
    case (state_q)
      S_IDLE, S_PASS, S_FAIL: begin
        if (al.efuse_autoload_vld) begin
          state_d = S_LOAD;
          tvld_d  = 1'b0;
          err_d   = 1'b0;
          blank_d = 1'b0;
        end
        if (al.efuse_autoload_done) begin
          state_d = S_CHECK;
          idx_d   = '0;
          acc_d   = '0;
        end
      end
      S_LOAD: begin
        if (al.efuse_autoload_done) begin
          state_d = S_CHECK;
          idx_d   = '0;
          acc_d   = '0;
        end
      end
      S_CHECK: begin
        if (idx_q != AW'(NB-1)) begin
          // Accumulate payload bytes 0..NB-2, one per cycle.
          acc_d = acc_q + shadow_q[idx_q];
          idx_d = idx_q + 1'b1;
        end else begin
          // Compare cycle: the only place trim_data moves outside reset.
          blank_d = cmp_blank;
          err_d   = cmp_err;
          tvld_d  = 1'b1;
          if (cmp_blank || cmp_err) begin
            state_d = S_FAIL;
            trim_d  = DEFAULT_TRIM;
          end else begin
            state_d = S_PASS;
            trim_d  = shadow_q;
          end
        end
      end
      default: state_d = S_IDLE;
    endcase
    busy_d = (state_d == S_LOAD) || (state_d == S_CHECK);
  end

  // State and datapath registers; reset discards any partial image.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= S_IDLE;
      shadow_q <= '0;
      idx_q    <= '0;
      acc_q    <= '0;
      trim_q   <= DEFAULT_TRIM;
      tvld_q   <= 1'b0;
      err_q    <= 1'b0;
      blank_q  <= 1'b0;
      busy_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      shadow_q <= shadow_d;
      idx_q    <= idx_d;
      acc_q    <= acc_d;
      trim_q   <= trim_d;
      tvld_q   <= tvld_d;
      err_q    <= err_d;
      blank_q  <= blank_d;
      busy_q   <= busy_d;
    end
  end

  assign rg_shadow_rdata   = shadow_q[rg_shadow_raddr];
  assign rg_shadow_sum_err = err_q;
  assign rg_shadow_blank   = blank_q;
  assign shadow_busy       = busy_q;

`ifdef EFUSE_SHADOW_OVR_EN
  // Override wins combinationally; the FSM keeps running underneath.
  assign trim_data = rg_trim_ovr_en ? rg_trim_ovr_data : trim_q;
  assign trim_vld  = rg_trim_ovr_en | tvld_q;
`else
  assign trim_data = trim_q;
  assign trim_vld  = tvld_q;
`endif
endmodule

// File: tb/tb_efuse_shadow.sv
// Directed + randomized bench for efuse_shadow against a byte-array model.
module tb_efuse_shadow;
  localparam int NB = 32;
  localparam int TW = NB*8;

  logic                  clk = 1'b0;
  logic                  rst_n = 1'b0;
  logic [4:0]            raddr = '0;
  logic [7:0]            rdata;
  logic [TW-1:0]         trim_data;
  logic                  trim_vld, sum_err, blank, busy;
`ifdef EFUSE_SHADOW_OVR_EN
  logic                  ovr_en = 1'b0;
  logic [TW-1:0]         ovr_data = '0;
`endif

  efuse_shadow_if al ();

  efuse_shadow #(.NB(NB)) dut (
    .clk               (clk),
    .rst_n             (rst_n),
    .al                (al.slave),
    .rg_shadow_raddr   (raddr),
    .rg_shadow_rdata   (rdata),
    .trim_data         (trim_data),
    .trim_vld          (trim_vld),
    .rg_shadow_sum_err (sum_err),
    .rg_shadow_blank   (blank),
`ifdef EFUSE_SHADOW_OVR_EN
    .rg_trim_ovr_en    (ovr_en),
    .rg_trim_ovr_data  (ovr_data),
`endif
    .shadow_busy       (busy)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Reference: plain byte array plus the checksum/blank rules.
  logic [7:0]    ref_sh [NB];
  logic          exp_err, exp_blank;
  logic [TW-1:0] exp_trim;
  logic [TW-1:0] pass_trim;

  task automatic chk(input string tag, input logic [TW-1:0] obs, input logic [TW-1:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic model_clear();
    for (int i = 0; i < NB; i++) ref_sh[i] = 8'h00;
  endtask

  task automatic model_write(input int a, input logic [7:0] d);
    if (a < NB) ref_sh[a] = d;
  endtask

  task automatic model_eval();
    int sum;
    sum = 0;
    exp_blank = 1'b1;
    for (int i = 0; i < NB - 1; i++) sum += ref_sh[i];
    for (int i = 0; i < NB; i++) if (ref_sh[i] != 0) exp_blank = 1'b0;
    exp_err = ((sum % 256) != ref_sh[NB-1]);
    exp_trim = '0;
    if (!(exp_blank || exp_err))
      for (int i = 0; i < NB; i++) exp_trim[8*i +: 8] = ref_sh[i];
  endtask

  task automatic send(input int a, input logic [7:0] d);
    al.efuse_autoload_vld  = 1'b1;
    al.efuse_autoload_addr = 8'(a);
    al.efuse_autoload_data = d;
    @(posedge clk); #1;
    al.efuse_autoload_vld  = 1'b0;
    model_write(a, d);
  endtask

  // Pulse done (optionally with a byte in the same cycle) and check latency/result.
  task automatic run_check(input string tag, input bit with_byte, input int a, input logic [7:0] d);
    al.efuse_autoload_done = 1'b1;
    if (with_byte) begin
      al.efuse_autoload_vld  = 1'b1;
      al.efuse_autoload_addr = 8'(a);
      al.efuse_autoload_data = d;
    end
    @(posedge clk); #1;
    al.efuse_autoload_done = 1'b0;
    al.efuse_autoload_vld  = 1'b0;
    if (with_byte) model_write(a, d);
    model_eval();
    for (int k = 1; k < NB; k++) begin
      @(posedge clk); #1;
    end
    chk({tag, "_vld_early"}, TW'(trim_vld), TW'(1'b0));
    chk({tag, "_busy"}, TW'(busy), TW'(1'b1));
    @(posedge clk); #1;
    chk({tag, "_vld"}, TW'(trim_vld), TW'(1'b1));
    chk({tag, "_busy_done"}, TW'(busy), TW'(1'b0));
    chk({tag, "_err"}, TW'(sum_err), TW'(exp_err));
    chk({tag, "_blank"}, TW'(blank), TW'(exp_blank));
    chk({tag, "_trim"}, trim_data, exp_trim);
  endtask

  task automatic check_rb(input string tag, input int a);
    raddr = 5'(a);
    #1;
    chk(tag, TW'(rdata), TW'(ref_sh[a]));
  endtask

  task automatic check_reset_vals(input string tag);
    chk({tag, "_vld"}, TW'(trim_vld), TW'(1'b0));
    chk({tag, "_busy"}, TW'(busy), TW'(1'b0));
    chk({tag, "_err"}, TW'(sum_err), TW'(1'b0));
    chk({tag, "_blank"}, TW'(blank), TW'(1'b0));
    chk({tag, "_trim"}, trim_data, TW'(0));
  endtask

  task automatic do_reset();
    @(posedge clk); #1;
    rst_n = 1'b0;
    model_clear();
    #2;
    @(posedge clk); #1;
    rst_n = 1'b1;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [7:0] d, good;
    al.efuse_autoload_vld  = 1'b0;
    al.efuse_autoload_addr = '0;
    al.efuse_autoload_data = '0;
    al.efuse_autoload_done = 1'b0;
    model_clear();
    repeat (3) @(posedge clk);
    #1;
    check_reset_vals("reset");
    check_rb("reset_rb", 7);
    rst_n = 1'b1;
    @(posedge clk); #1;

    // Good image: bytes i+1, checksum 0xF0.
    for (int i = 0; i < NB - 1; i++) send(i, 8'(i + 1));
    send(NB - 1, 8'hF0);
    run_check("pass", 1'b0, 0, 8'h00);
    chk("pass_byte0", TW'(trim_data[7:0]), TW'(8'h01));
    check_rb("pass_rb5", 5);
    pass_trim = trim_data;

    // New vld after PASS: trim_vld drops, busy rises, trim_data held.
    send(NB - 1, 8'hF1);
    chk("reload_vld", TW'(trim_vld), TW'(1'b0));
    chk("reload_busy", TW'(busy), TW'(1'b1));
    chk("reload_hold", trim_data, pass_trim);
`ifdef EFUSE_SHADOW_OVR_EN
    ovr_en = 1'b1;
    ovr_data = {NB{8'h5A}};
    #1;
    chk("ovr_trim", trim_data, {NB{8'h5A}});
    chk("ovr_vld", TW'(trim_vld), TW'(1'b1));
    ovr_en = 1'b0;
    #1;
`endif
    run_check("badsum", 1'b0, 0, 8'h00);

    // done with no vld after reset: blank image.
    do_reset();
    check_reset_vals("reset2");
    run_check("blank", 1'b0, 0, 8'h00);

    // Out-of-range address ignored; byte 31 arrives together with done.
    do_reset();
    for (int i = 0; i < NB - 1; i++) send(i, 8'(i + 1));
    send(8'h40, 8'hAA);
    check_rb("oor_rb0", 0);
    run_check("vld_done", 1'b1, NB - 1, 8'hF0);

    // Reset while checking at idx=10.
    send(3, 8'h77);
    al.efuse_autoload_done = 1'b1;
    @(posedge clk); #1;
    al.efuse_autoload_done = 1'b0;
    repeat (10) @(posedge clk);
    #1;
    rst_n = 1'b0;
    model_clear();
    #1;
    check_reset_vals("midreset");
    check_rb("midreset_rb3", 3);
    @(posedge clk); #1;
    rst_n = 1'b1;

    // Randomized images: random payload, rewrites, stray addresses, good/bad/blank checksums.
    for (int it = 0; it < 8; it++) begin
      bit zero_img;
      zero_img = ($urandom_range(0, 4) == 0);
      for (int i = 0; i < NB - 1; i++) send(i, zero_img ? 8'h00 : 8'($urandom));
      for (int j = 0; j < 3; j++) begin
        if ($urandom_range(0, 1) == 1) send($urandom_range(NB, 255), 8'($urandom));
        else if (!zero_img) send($urandom_range(0, NB - 2), 8'($urandom));
      end
      good = 8'h00;
      for (int i = 0; i < NB - 1; i++) good = good + ref_sh[i];
      d = ($urandom_range(0, 1) == 1) ? good : good + 8'($urandom_range(1, 255));
      if ($urandom_range(0, 1) == 1) begin
        send(NB - 1, d);
        run_check($sformatf("rnd%0d", it), 1'b0, 0, 8'h00);
      end else begin
        run_check($sformatf("rnd%0d", it), 1'b1, NB - 1, d);
      end
      check_rb($sformatf("rnd%0d_rb", it), $urandom_range(0, NB - 1));
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
